sram_bus_ctrl: RTL and testbench
================================

Name: sram_bus_ctrl

Overview:
- Synchronous master that converts single-beat read/write requests from the sound-engine side into the asynchronous 2048x8 work SRAM bus.
- The SRAM bus signals are: address, bidirectional data, active-low write enable and active-low output enable.
- Sits directly upstream of the SRAM. It generates WE_n/OE_n strobes with programmable setup, pulse and hold phases.
- The SRAM commits a write on the rising edge of WE_n while OE_n is high.

Parameters:
- DATA_WIDTH, 8, SRAM data width
- ADDR_WIDTH, 11, SRAM address width
- SETUP_CYC, 1, write cycles with address/data valid before WE_n falls (min 1, max 255)
- PULSE_CYC, 2, write cycles WE_n held low (min 1, max 255)
- HOLD_CYC, 1, write cycles address/data held after WE_n rises (min 1, max 255)
- READ_CYC, 2, read cycles OE_n held low before data capture (min 1, max 255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted when req_valid&req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse, rsp_rdata valid
- rsp_rdata  out  DATA_WIDTH  read data
- sram_address  out  ADDR_WIDTH  SRAM address
- sram_data_out  out  DATA_WIDTH  value for SRAM data pins when sram_data_oe=1
- sram_data_oe  out  1  top level drives data pins with sram_data_out, else high-Z
- sram_data_in  in  DATA_WIDTH  SRAM data pins as read
- sram_we_n  out  1  SRAM write enable, active low
- sram_oe_n  out  1  SRAM output enable, active low

Behaviour:
- One clock (clk); rst synchronous, active-high. All outputs are registered with no combinational path from req_* to sram_*.
- Reset values:
  - state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0
  - sram_address=0, sram_data_out=0, sram_data_oe=0
  - sram_we_n=1, sram_oe_n=1
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS. An 8-bit phase counter is loaded with (phase length - 1) on each state entry and decremented; the state advances when the counter reaches 0.
- IDLE:
  - req_ready=1, we_n=1, oe_n=1, data_oe=0.
  - On accept, latch addr/wdata into sram_address/sram_data_out. Go to W_SETUP if req_write, else R_ACCESS.
- W_SETUP (SETUP_CYC cycles): data_oe=1, we_n=1, oe_n=1.
- W_PULSE (PULSE_CYC cycles): we_n=0, data and address stable.
- W_HOLD (HOLD_CYC cycles):
  - we_n=1; its rising edge occurs at entry and is the commit point.
  - data_oe stays 1 and address stays stable through the whole phase.
  - Exit to IDLE, where data_oe=0.
- R_ACCESS (READ_CYC cycles):
  - oe_n=0, we_n=1, data_oe=0.
  - On the final cycle's edge, capture sram_data_in into rsp_rdata, set rsp_valid=1 and go to IDLE with oe_n=1.
- rsp_valid is high exactly one cycle, concurrent with the first IDLE cycle. Writes produce no rsp_valid.
- Latency:
  - Write accept to next req_ready: SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
  - Read accept to rsp_valid: READ_CYC+1 cycles.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high. Throughput is one request per (phase total + 1) cycles.
- Bus contention rules:
  - data_oe=1 and oe_n=0 are never simultaneously true.
  - we_n=0 and oe_n=0 are never simultaneously true.
  - data_oe is only asserted in states where oe_n was already 1 on the previous cycle; this is guaranteed by the mandatory IDLE cycle.
- req_* inputs are ignored when req_ready=0.
- Address wrap: none; the address is passed through unmodified.
- Reset mid-operation:
  - Next edge forces reset values. An in-flight read is dropped with no rsp_valid.
  - Reset during W_PULSE raises we_n while data_oe drops, so that write's SRAM location is undefined. All other locations are unaffected.
  - Reset during W_SETUP or W_HOLD leaves SRAM contents correct.

Test Plan:
- Reset then idle: hold rst 3 cycles -> we_n=1, oe_n=1, data_oe=0, req_ready=1, rsp_valid=0 throughout.
- Single write, defaults: write addr 0x123, data 0xA5.
  - Required response: we_n low exactly 2 cycles, starting 1 cycle after data_oe rises; data_oe stays high 1 cycle after we_n rises; req_ready returns 5 cycles after accept.
  - Check: SRAM model mem[0x123]=0xA5.
- Write then read: write 0x7FF<-0x3C, then read 0x7FF -> oe_n low 2 cycles, rsp_valid pulse 3 cycles after accept, rsp_rdata=0x3C.
- Back-to-back stream: reads of 0x000..0x00F after writing pattern addr^0x5A, with req_valid held high.
  - Required response: 16 rsp_valid pulses in order with correct data, one accept every 3 cycles.
  - Check: protocol checker sees no data_oe&~oe_n and no ~we_n&~oe_n in any cycle.
- Parameter sweep: SETUP=3, PULSE=1, HOLD=2, READ=4, write 0x400<-0xFF then read.
  - Required response: phase lengths exactly 3/1/2 and 4 cycles; readback 0xFF.
- Reset mid-access: assert rst during R_ACCESS cycle 1 -> no rsp_valid, oe_n=1 next cycle. A subsequent read of a previously written location returns the correct data.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
// Single-beat request to asynchronous SRAM bus master with programmable
// write setup/pulse/hold phases and read access time. All outputs registered.
module sram_bus_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned READ_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  sram_data_oe,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    output logic                  sram_we_n,
    output logic                  sram_oe_n
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  doe_q, doe_d;
    logic                  we_n_q, we_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  cnt_done;

    assign cnt_done = (cnt_q == '0);

    // State, phase counter and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    // Next state and next output values for the state being entered
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
        we_n_d      = we_n_q;
        oe_n_d      = oe_n_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    dout_d  = req_wdata;
                    ready_d = 1'b0;
                    if (req_write) begin
                        state_d = W_SETUP;
                        cnt_d   = SETUP_LD;
                        doe_d   = 1'b1;
                    end else begin
                        state_d = R_ACCESS;
                        cnt_d   = READ_LD;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            W_SETUP: begin
                if (cnt_done) begin
                    state_d = W_PULSE;
                    cnt_d   = PULSE_LD;
                    we_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            W_PULSE: begin
                // Rising WE_n on entry to hold is the SRAM commit point
                if (cnt_done) begin
                    state_d = W_HOLD;
                    cnt_d   = HOLD_LD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            W_HOLD: begin
                if (cnt_done) begin
                    state_d = IDLE;
                    doe_d   = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            R_ACCESS: begin
                if (cnt_done) begin
                    state_d     = IDLE;
                    oe_n_d      = 1'b1;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rdata_d     = sram_data_in;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
                doe_d   = 1'b0;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    assign req_ready     = ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign sram_address  = addr_q;
    assign sram_data_out = dout_q;
    assign sram_data_oe  = doe_q;
    assign sram_we_n     = we_n_q;
    assign sram_oe_n     = oe_n_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed self-checking bench for sram_bus_ctrl: default and swept timing
// instances, each attached to a behavioural 2048x8 asynchronous SRAM.
module tb_sram_bus_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rv0 = 1'b0;
    logic          rv1 = 1'b0;

    logic          rdy0, rspv0, doe0, we0, oe0;
    logic [DW-1:0] rd0, do0, di0;
    logic [AW-1:0] a0;
    logic          rdy1, rspv1, doe1, we1, oe1;
    logic [DW-1:0] rd1, do1, di1;
    logic [AW-1:0] a1;

    logic [DW-1:0] mem0 [0:2047];
    logic [DW-1:0] mem1 [0:2047];

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [16:1]   tr_we, tr_oe, tr_doe, tr_rdy, tr_rv;
    logic [DW-1:0] tr_rd [1:16];

    always #5 clk = ~clk;

    sram_bus_ctrl dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_ready(rdy0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv0), .rsp_rdata(rd0),
        .sram_address(a0), .sram_data_out(do0), .sram_data_oe(doe0),
        .sram_data_in(di0), .sram_we_n(we0), .sram_oe_n(oe0)
    );

    sram_bus_ctrl #(
        .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .READ_CYC(4)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv1), .req_ready(rdy1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv1), .rsp_rdata(rd1),
        .sram_address(a1), .sram_data_out(do1), .sram_data_oe(doe1),
        .sram_data_in(di1), .sram_we_n(we1), .sram_oe_n(oe1)
    );

    // Behavioural SRAMs: drive data while OE_n low, commit on WE_n rising
    assign di0 = (oe0 === 1'b0) ? mem0[a0] : 8'h00;
    assign di1 = (oe1 === 1'b0) ? mem1[a1] : 8'h00;

    always @(posedge we0) if (doe0 === 1'b1 && oe0 === 1'b1) mem0[a0] = do0;
    always @(posedge we1) if (doe1 === 1'b1 && oe1 === 1'b1) mem1[a1] = do1;

    // Bus contention monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (doe0 === 1'b1 && oe0 === 1'b0) viol++;
            if (we0 === 1'b0 && oe0 === 1'b0) viol++;
            if (doe1 === 1'b1 && oe1 === 1'b0) viol++;
            if (we1 === 1'b0 && oe1 === 1'b0) viol++;
        end
    end

    function automatic int first_idx(input logic [16:1] v, input logic val, input int n);
        for (int k = 1; k <= n; k++) if (v[k] === val) return k;
        return 0;
    endfunction

    function automatic int count_val(input logic [16:1] v, input logic val, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (v[k] === val) c++;
        return c;
    endfunction

    // Issue one request to the selected instance and record n cycles after accept
    task automatic run_req(input bit sel, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int n);
        req_write = w; req_addr = a; req_wdata = d;
        rv0 = !sel; rv1 = sel;
        @(posedge clk); #1;
        rv0 = 1'b0; rv1 = 1'b0;
        tr_we = '0; tr_oe = '0; tr_doe = '0; tr_rdy = '0; tr_rv = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (sel) begin
                tr_we[k] = we1; tr_oe[k] = oe1; tr_doe[k] = doe1;
                tr_rdy[k] = rdy1; tr_rv[k] = rspv1; tr_rd[k] = rd1;
            end else begin
                tr_we[k] = we0; tr_oe[k] = oe0; tr_doe[k] = doe0;
                tr_rdy[k] = rdy0; tr_rv[k] = rspv0; tr_rd[k] = rd0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({we0, oe0, doe0, rdy0, rspv0} !== 5'b11010) begin
                errors++;
                $display("FAIL reset_ctl0 cyc%0d got %b exp 11010", i, {we0, oe0, doe0, rdy0, rspv0});
            end
            checks++;
            if ({we1, oe1, doe1, rdy1, rspv1} !== 5'b11010) begin
                errors++;
                $display("FAIL reset_ctl1 cyc%0d got %b exp 11010", i, {we1, oe1, doe1, rdy1, rspv1});
            end
        end
        checks++;
        if ({a0, do0, rd0} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h exp 0/0/0", a0, do0, rd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({we0, oe0, doe0, rdy0, rspv0} !== 5'b11010) begin
            errors++;
            $display("FAIL idle_ctl0 got %b exp 11010", {we0, oe0, doe0, rdy0, rspv0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_write;
        run_req(1'b0, 1'b1, 11'h123, 8'hA5, 6);
        checks++;
        if (first_idx(tr_doe, 1'b1, 6) !== 1) begin
            errors++;
            $display("FAIL wr_doe_rise got %0d exp 1", first_idx(tr_doe, 1'b1, 6));
        end
        checks++;
        if (first_idx(tr_we, 1'b0, 6) !== 2) begin
            errors++;
            $display("FAIL wr_we_fall got %0d exp 2", first_idx(tr_we, 1'b0, 6));
        end
        checks++;
        if (count_val(tr_we, 1'b0, 6) !== 2) begin
            errors++;
            $display("FAIL wr_we_len got %0d exp 2", count_val(tr_we, 1'b0, 6));
        end
        checks++;
        if (first_idx(tr_doe, 1'b0, 6) !== 5) begin
            errors++;
            $display("FAIL wr_doe_fall got %0d exp 5", first_idx(tr_doe, 1'b0, 6));
        end
        checks++;
        if (first_idx(tr_rdy, 1'b1, 6) !== 5) begin
            errors++;
            $display("FAIL wr_ready_lat got %0d exp 5", first_idx(tr_rdy, 1'b1, 6));
        end
        checks++;
        if (count_val(tr_rv, 1'b1, 6) !== 0) begin
            errors++;
            $display("FAIL wr_no_rsp got %0d exp 0", count_val(tr_rv, 1'b1, 6));
        end
        checks++;
        if (mem0[11'h123] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_mem got %h exp a5", mem0[11'h123]);
        end
    endtask

    task automatic test_write_read;
        run_req(1'b0, 1'b1, 11'h7FF, 8'h3C, 6);
        checks++;
        if (mem0[11'h7FF] !== 8'h3C) begin
            errors++;
            $display("FAIL wrrd_mem got %h exp 3c", mem0[11'h7FF]);
        end
        run_req(1'b0, 1'b0, 11'h7FF, 8'h00, 5);
        checks++;
        if (first_idx(tr_oe, 1'b0, 5) !== 1 || count_val(tr_oe, 1'b0, 5) !== 2) begin
            errors++;
            $display("FAIL rd_oe_len got first %0d len %0d exp 1 2",
                     first_idx(tr_oe, 1'b0, 5), count_val(tr_oe, 1'b0, 5));
        end
        checks++;
        if (first_idx(tr_rv, 1'b1, 5) !== 3 || count_val(tr_rv, 1'b1, 5) !== 1) begin
            errors++;
            $display("FAIL rd_rsp_lat got first %0d cnt %0d exp 3 1",
                     first_idx(tr_rv, 1'b1, 5), count_val(tr_rv, 1'b1, 5));
        end
        checks++;
        if (tr_rd[3] !== 8'h3C) begin
            errors++;
            $display("FAIL rd_data got %h exp 3c", tr_rd[3]);
        end
    endtask

    task automatic test_back_to_back;
        int acc_cyc [0:15];
        int acc = 0;
        int rsp = 0;
        int cyc = 0;
        int bad_gap = 0;
        bit accepting;
        for (int i = 0; i < 16; i++)
            run_req(1'b0, 1'b1, AW'(i), 8'(i) ^ 8'h5A, 5);
        req_write = 1'b0; req_addr = '0; rv0 = 1'b1;
        while (rsp < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rspv0 === 1'b1) begin
                checks++;
                if (rd0 !== (8'(rsp) ^ 8'h5A)) begin
                    errors++;
                    $display("FAIL b2b_data idx %0d got %h exp %h", rsp, rd0, 8'(rsp) ^ 8'h5A);
                end
                rsp++;
            end
            accepting = (rdy0 === 1'b1) && (rv0 === 1'b1);
            @(posedge clk); #1;
            if (accepting) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc == 16) rv0 = 1'b0;
                else req_addr = AW'(acc);
            end
        end
        rv0 = 1'b0;
        checks++;
        if (rsp !== 16 || acc !== 16) begin
            errors++;
            $display("FAIL b2b_count got rsp %0d acc %0d exp 16 16", rsp, acc);
        end
        for (int i = 1; i < acc; i++)
            if (acc_cyc[i] - acc_cyc[i-1] != 3) bad_gap++;
        checks++;
        if (bad_gap !== 0) begin
            errors++;
            $display("FAIL b2b_rate got %0d bad gaps exp 0", bad_gap);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL b2b_contention got %0d exp 0", viol);
        end
    endtask

    task automatic test_param_sweep;
        run_req(1'b1, 1'b1, 11'h400, 8'hFF, 8);
        checks++;
        if (first_idx(tr_doe, 1'b1, 8) !== 1 || first_idx(tr_we, 1'b0, 8) !== 4) begin
            errors++;
            $display("FAIL sw_setup got doe %0d we %0d exp 1 4",
                     first_idx(tr_doe, 1'b1, 8), first_idx(tr_we, 1'b0, 8));
        end
        checks++;
        if (count_val(tr_we, 1'b0, 8) !== 1) begin
            errors++;
            $display("FAIL sw_pulse got %0d exp 1", count_val(tr_we, 1'b0, 8));
        end
        checks++;
        if (first_idx(tr_doe, 1'b0, 8) !== 7 || first_idx(tr_rdy, 1'b1, 8) !== 7) begin
            errors++;
            $display("FAIL sw_hold got doe_fall %0d ready %0d exp 7 7",
                     first_idx(tr_doe, 1'b0, 8), first_idx(tr_rdy, 1'b1, 8));
        end
        run_req(1'b1, 1'b0, 11'h400, 8'h00, 7);
        checks++;
        if (first_idx(tr_oe, 1'b0, 7) !== 1 || count_val(tr_oe, 1'b0, 7) !== 4) begin
            errors++;
            $display("FAIL sw_read_len got first %0d len %0d exp 1 4",
                     first_idx(tr_oe, 1'b0, 7), count_val(tr_oe, 1'b0, 7));
        end
        checks++;
        if (first_idx(tr_rv, 1'b1, 7) !== 5) begin
            errors++;
            $display("FAIL sw_rsp_lat got %0d exp 5", first_idx(tr_rv, 1'b1, 7));
        end
        checks++;
        if (tr_rd[5] !== 8'hFF) begin
            errors++;
            $display("FAIL sw_data got %h exp ff", tr_rd[5]);
        end
    endtask

    task automatic test_reset_mid_read;
        int stray = 0;
        req_write = 1'b0; req_addr = 11'h123; rv0 = 1'b1;
        @(posedge clk); #1;
        rv0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({oe0, rspv0, rdy0} !== 3'b101) begin
            errors++;
            $display("FAIL rst_mid got oe/rsp/rdy %b exp 101", {oe0, rspv0, rdy0});
        end
        for (int i = 0; i < 4; i++) begin
            if (rspv0 !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rst_no_rsp got %0d exp 0", stray);
        end
        @(posedge clk); #1;
        run_req(1'b0, 1'b0, 11'h7FF, 8'h00, 5);
        checks++;
        if (tr_rv[3] !== 1'b1 || tr_rd[3] !== 8'h3C) begin
            errors++;
            $display("FAIL rst_readback got v %b d %h exp 1 3c", tr_rv[3], tr_rd[3]);
        end
        run_req(1'b0, 1'b0, 11'h123, 8'h00, 5);
        checks++;
        if (tr_rv[3] !== 1'b1 || tr_rd[3] !== 8'hA5) begin
            errors++;
            $display("FAIL rst_readback2 got v %b d %h exp 1 a5", tr_rv[3], tr_rd[3]);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL final_contention got %0d exp 0", viol);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_write_read;
        test_back_to_back;
        test_param_sweep;
        test_reset_mid_read;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
